// File: rtl/episode_tracker_pkg.sv
// Shared types for the episode tracker and the metacognition block that
// consumes its outputs: the tracker FSM state encoding and the strength ceiling.
package episode_tracker_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    PRIMED = 2'd1,
    TRACK  = 2'd2
  } state_e;

  localparam logic [3:0] STR_MAX = 4'd15;

  // Add an increment to a 4-bit strength, clamping at STR_MAX.
  function automatic logic [3:0] str_add_sat(input logic [3:0] s, input logic [3:0] inc);
    logic [4:0] sum;
    sum = {1'b0, s} + {1'b0, inc};
    if (sum > {1'b0, STR_MAX}) begin
      return STR_MAX;
    end else begin
      return sum[3:0];
    end
  endfunction

endpackage

// File: rtl/episode_tracker_if.sv
// Episode-side bus: the pattern encoder drives patterns and theta ticks in,
// the tracker drives the stability score and mismatch pulse out.
interface episode_if #(
  parameter int PAT_W = 16
);
  logic             theta_tick;
  logic             pattern_valid;
  logic [PAT_W-1:0] pattern;
  logic [3:0]       ep_strength;
  logic             ep_valid;
  logic             input_mismatch;
  logic [PAT_W-1:0] ep_pattern;

  modport master (
    output theta_tick, pattern_valid, pattern,
    input  ep_strength, ep_valid, input_mismatch, ep_pattern
  );

  modport slave (
    input  theta_tick, pattern_valid, pattern,
    output ep_strength, ep_valid, input_mismatch, ep_pattern
  );
endinterface

// File: rtl/episode_tracker_popcount.sv
// Generic population count: number of set bits in vec_i.
module popcount #(
  parameter int W = 16
) (
  input  logic [W-1:0]           vec_i,
  output logic [$clog2(W+1)-1:0] cnt_o
);
  localparam int CW = $clog2(W + 1);

  // Sum every bit; synthesis balances the chain into an adder tree.
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < W; i++) begin
      cnt_o = cnt_o + CW'(vec_i[i]);
    end
  end
endmodule

// File: rtl/episode_tracker.sv
// Episode tracker: captures a stored episode pattern, counts near/far gamma
// patterns per theta window and turns the window verdict into a stability score.
// A stored episode that keeps losing is replaced by the last far pattern seen.
module episode_tracker
  import episode_tracker_pkg::*;
#(
  parameter int PAT_W         = 16,
  parameter int MATCH_DIST    = 2,
  parameter int MISMATCH_DIST = 6,
  parameter int STEP_UP       = 2,
  parameter int STEP_DOWN     = 1,
  parameter int INIT_STR      = 1,
  parameter int CNT_W         = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  episode_if.slave   ep_if,
  output state_e     state_o
);
  localparam int DIST_W = $clog2(PAT_W + 1);

  state_e           state_q, state_d;
  logic [PAT_W-1:0] ep_pattern_q, ep_pattern_d;
  logic [3:0]       strength_q, strength_d;
  logic             valid_q, valid_d;
  logic             mismatch_q, mismatch_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
  logic [PAT_W-1:0] last_miss_q, last_miss_d;

  logic [DIST_W-1:0] dist_s;
  logic              is_match_s;
  logic              is_miss_s;
  logic [CNT_W-1:0]  match_base_s;
  logic [CNT_W-1:0]  miss_base_s;

  // Saturating increment for the per-window counters.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    if (c == {CNT_W{1'b1}}) begin
      return c;
    end else begin
      return c + CNT_W'(1);
    end
  endfunction

  // Distance is always taken against the episode as it stands before this edge.
  popcount #(.W(PAT_W)) u_popcount (
    .vec_i (ep_if.pattern ^ ep_pattern_q),
    .cnt_o (dist_s)
  );

  assign is_match_s = (dist_s <= DIST_W'(MATCH_DIST));
  assign is_miss_s  = (dist_s >= DIST_W'(MISMATCH_DIST));

  // Next-state: capture, per-pattern counting and theta-window evaluation.
  always_comb begin
    state_d      = state_q;
    ep_pattern_d = ep_pattern_q;
    strength_d   = strength_q;
    valid_d      = valid_q;
    mismatch_d   = 1'b0;
    match_cnt_d  = match_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    last_miss_d  = last_miss_q;
    match_base_s = match_cnt_q;
    miss_base_s  = miss_cnt_q;

    case (state_q)
      EMPTY: begin
        if (ep_if.pattern_valid) begin
          ep_pattern_d = ep_if.pattern;
          strength_d   = 4'(INIT_STR);
          state_d      = PRIMED;
        end else begin
          state_d = EMPTY;
        end
      end

      PRIMED, TRACK: begin
        if (ep_if.theta_tick) begin
          // Judge the closing window on its own counts; a sample arriving
          // on the same edge lands in the fresh window.
          match_base_s = '0;
          miss_base_s  = '0;
          if ((match_cnt_q == '0) && (miss_cnt_q == '0)) begin
            strength_d = strength_q;
          end else if (match_cnt_q >= miss_cnt_q) begin
            strength_d = str_add_sat(strength_q, 4'(STEP_UP));
          end else if (strength_q > 4'(STEP_DOWN)) begin
            strength_d = strength_q - 4'(STEP_DOWN);
          end else begin
            ep_pattern_d = last_miss_q;
            strength_d   = 4'(INIT_STR);
          end
          valid_d = 1'b1;
          state_d = TRACK;
        end else begin
          match_base_s = match_cnt_q;
          miss_base_s  = miss_cnt_q;
        end

        match_cnt_d = match_base_s;
        miss_cnt_d  = miss_base_s;

        if (ep_if.pattern_valid) begin
          if (is_match_s) begin
            match_cnt_d = cnt_inc(match_base_s);
          end else if (is_miss_s) begin
            miss_cnt_d  = cnt_inc(miss_base_s);
            last_miss_d = ep_if.pattern;
            mismatch_d  = 1'b1;
          end else begin
            match_cnt_d = match_base_s;
            miss_cnt_d  = miss_base_s;
          end
        end else begin
          mismatch_d = 1'b0;
        end
      end

      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // State and output registers; reset discards any partially counted window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      ep_pattern_q <= '0;
      strength_q   <= 4'd0;
      valid_q      <= 1'b0;
      mismatch_q   <= 1'b0;
      match_cnt_q  <= '0;
      miss_cnt_q   <= '0;
      last_miss_q  <= '0;
    end else begin
      state_q      <= state_d;
      ep_pattern_q <= ep_pattern_d;
      strength_q   <= strength_d;
      valid_q      <= valid_d;
      mismatch_q   <= mismatch_d;
      match_cnt_q  <= match_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      last_miss_q  <= last_miss_d;
    end
  end

  assign ep_if.ep_strength    = strength_q;
  assign ep_if.ep_valid       = valid_q;
  assign ep_if.input_mismatch = mismatch_q;
  assign ep_if.ep_pattern     = ep_pattern_q;
  assign state_o              = state_q;

endmodule

// File: tb/tb_episode_tracker.sv
// Directed bench for episode_tracker. Stimulus pushes hand-computed expectations
// into queues; a monitor pops them when the DUT presents a result (the cycle
// after each pattern_valid / theta_tick) and compares.
module tb_episode_tracker;
  import episode_tracker_pkg::*;

  typedef struct packed {
    logic [3:0]  str;
    logic        vld;
    logic [15:0] pat;
  } win_t;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_e state_s;

  int   errors = 0;
  int   checks = 0;
  bit   mis_q[$];
  win_t win_q[$];

  always #5 clk = ~clk;

  episode_if #(.PAT_W(16)) bus ();

  episode_tracker #(.PAT_W(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ep_if   (bus),
    .state_o (state_s)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Samples what was presented on each edge, then checks outputs on the falling edge.
  task automatic monitor();
    bit   pv;
    bit   tk;
    win_t ew;
    forever begin
      @(posedge clk);
      pv = bus.pattern_valid;
      tk = bus.theta_tick;
      @(negedge clk);
      if (pv) begin
        if (mis_q.size() == 0) begin
          check("mis_queue_underflow", 32'd1, 32'd0);
        end else begin
          check("input_mismatch", 32'(bus.input_mismatch), 32'(mis_q.pop_front()));
        end
      end else begin
        check("mismatch_idle", 32'(bus.input_mismatch), 32'd0);
      end
      if (tk) begin
        if (win_q.size() == 0) begin
          check("win_queue_underflow", 32'd1, 32'd0);
        end else begin
          ew = win_q.pop_front();
          check("ep_strength", 32'(bus.ep_strength), 32'(ew.str));
          check("ep_valid",    32'(bus.ep_valid),    32'(ew.vld));
          check("ep_pattern",  32'(bus.ep_pattern),  32'(ew.pat));
        end
      end
    end
  endtask

  // One cycle of stimulus, called just after a rising edge.
  task automatic drive(input bit pv, input logic [15:0] pat, input bit tk, input bit emis,
                       input logic [3:0] estr, input bit ev, input logic [15:0] epat);
    if (pv) mis_q.push_back(emis);
    if (tk) win_q.push_back('{str: estr, vld: ev, pat: epat});
    bus.pattern_valid = pv;
    bus.pattern       = pat;
    bus.theta_tick    = tk;
    @(posedge clk);
    #1;
    bus.pattern_valid = 1'b0;
    bus.pattern       = 16'h0000;
    bus.theta_tick    = 1'b0;
  endtask

  task automatic send(input logic [15:0] pat, input bit emis);
    drive(1'b1, pat, 1'b0, emis, 4'd0, 1'b0, 16'h0000);
  endtask

  task automatic tick(input logic [3:0] estr, input bit ev, input logic [15:0] epat);
    drive(1'b0, 16'h0000, 1'b1, 1'b0, estr, ev, epat);
  endtask

  task automatic idle();
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, 16'h0000);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_strength", 32'(bus.ep_strength), 32'd0);
    check("rst_valid",    32'(bus.ep_valid),    32'd0);
    check("rst_mismatch", 32'(bus.input_mismatch), 32'd0);
    check("rst_pattern",  32'(bus.ep_pattern),  32'd0);
    check("rst_state",    32'(state_s),         32'(EMPTY));
  endtask

  initial begin
    int e;
    bus.pattern_valid = 1'b0;
    bus.pattern       = 16'h0000;
    bus.theta_tick    = 1'b0;
    fork
      monitor();
    join_none
    do_reset();

    // 1: ticks with no episode are ignored
    repeat (3) tick(4'd0, 1'b0, 16'h0000);
    check("t1_state", 32'(state_s), 32'(EMPTY));

    // 2: capture, first winning window, then saturation
    send(16'hA5A5, 1'b0);
    check("t2_primed", 32'(state_s), 32'(PRIMED));
    repeat (4) send(16'hA5A5, 1'b0);
    tick(4'd3, 1'b1, 16'hA5A5);
    check("t2_track", 32'(state_s), 32'(TRACK));
    for (int i = 0; i < 7; i++) begin
      e = 3 + 2 * (i + 1);
      if (e > 15) e = 15;
      send(16'hA5A5, 1'b0);
      tick(4'(e), 1'b1, 16'hA5A5);
    end

    // 3: far patterns pulse for one cycle each; middle distance is neutral
    do_reset();
    send(16'hA5A5, 1'b0);
    send(16'hA5A5, 1'b0);
    tick(4'd3, 1'b1, 16'hA5A5);
    send(16'hA55A, 1'b1);
    idle();
    send(16'hA5AA, 1'b0);
    send(16'hA55A, 1'b1);
    send(16'hA55A, 1'b1);
    tick(4'd2, 1'b1, 16'hA5A5);

    // 4: losing at strength 1 replaces the episode with the last far pattern
    send(16'hA55A, 1'b1);
    tick(4'd1, 1'b1, 16'hA5A5);
    send(16'hA55A, 1'b1);
    send(16'h00FF, 1'b1);
    tick(4'd1, 1'b1, 16'h00FF);

    // 5: tick and matching pattern together; the sample seeds the next window
    send(16'h00FF, 1'b0);
    drive(1'b1, 16'h00FF, 1'b1, 1'b0, 4'd3, 1'b1, 16'h00FF);
    send(16'hFF00, 1'b1);
    tick(4'd5, 1'b1, 16'h00FF);

    // 6: reset mid-window discards counts; next pattern re-primes
    send(16'hFF00, 1'b1);
    send(16'hFF00, 1'b1);
    do_reset();
    send(16'h1234, 1'b0);
    check("t6_primed", 32'(state_s), 32'(PRIMED));
    tick(4'd1, 1'b1, 16'h1234);

    repeat (3) idle();
    check("scoreboard_drained", 32'(mis_q.size() + win_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
